acl_int_event_tracker: RTL

Converts the debounced accelerometer interrupt level into a held service request for the ACL driver FSM, with acknowledge handshake, overrun and stuck-line detection, and an optional event counter. It sits directly downstream of the interrupt debouncer and directly upstream of the driver that reads the accelerometer status registers.

---
 rtl/acl_int_event_tracker.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/acl_int_event_tracker.sv
// acl_int_event_tracker
// Turns the debounced accelerometer interrupt level into a held service
// request for the ACL driver, with an acknowledge handshake, a sticky
// overrun flag, a sticky stuck-line flag and an optional event counter.
//
// Optional feature: define ACL_INT_EVT_COUNTER_EN to add the saturating
// o_evt_count output. Without it the counter logic and port are absent
// and everything else behaves the same.
//
// Edge handling: the rise pulse is registered, so a 0->1 on i_int_deb
// before edge n is acted on by the FSM at edge n+1 (request visible two
// cycles after the input change). The counter and the overrun flag use
// the same registered pulse, so they move together with the FSM.
// Ack and the level tests in the FSM use i_int_deb directly.

module acl_int_event_tracker #(
  parameter int unsigned C_STUCK_CYCLES = 20000,
  parameter int unsigned C_CNT_BITS     = 8
) (
  input  logic                  i_clk_20mhz,
  input  logic                  i_rstn_20mhz,
  input  logic                  i_int_deb,
  input  logic                  i_ack,
  input  logic                  i_clr,
  output logic                  o_int_req,
  output logic                  o_int_overrun,
  output logic                  o_int_stuck
`ifdef ACL_INT_EVT_COUNTER_EN
  ,
  output logic [C_CNT_BITS-1:0] o_evt_count
`endif
);

  localparam int unsigned TW = $clog2(C_STUCK_CYCLES + 1);
  localparam logic [TW-1:0] STUCK_MAX = TW'(C_STUCK_CYCLES);
  localparam logic [TW-1:0] TIMER_ONE = {{(TW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_PEND     = 2'b01,
    ST_WAIT_LOW = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic            int_prev_q;
  logic            rise_s;
  logic            rise_q;
  logic            req_q, req_d;
  logic            overrun_q, overrun_d;
  logic            ovr_set_s;
  logic            stuck_q, stuck_d;
  logic            stuck_set_s;
  logic [TW-1:0]   timer_q, timer_d;

  // Combinational rise detect against the previous sampled level.
  always_comb begin
    rise_s = i_int_deb & ~int_prev_q;
  end

  // Input history and registered rise pulse.
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      int_prev_q <= 1'b0;
      rise_q     <= 1'b0;
    end else begin
      int_prev_q <= i_int_deb;
      rise_q     <= rise_s;
    end
  end

  // Next-state logic of the request FSM; request output follows the next state.
  always_comb begin
    state_d   = state_q;
    ovr_set_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise_q) begin
          state_d = ST_PEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (i_ack && rise_q) begin
          // Ack retires the old event while a new one arrives: keep serving.
          state_d = ST_PEND;
        end else if (i_ack && i_int_deb) begin
          state_d = ST_WAIT_LOW;
        end else if (i_ack) begin
          state_d = ST_IDLE;
        end else if (rise_q) begin
          ovr_set_s = 1'b1;
          state_d   = ST_PEND;
        end else begin
          state_d = ST_PEND;
        end
      end
      ST_WAIT_LOW: begin
        // A short low gap already produced a new rise; do not lose it.
        if (rise_q) begin
          state_d = ST_PEND;
        end else if (!i_int_deb) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_LOW;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    req_d = (state_d == ST_PEND);
  end

  // FSM state and registered request output.
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  // Stuck timer: counts consecutive high samples, holding at the limit.
  always_comb begin
    if (!i_int_deb) begin
      timer_d = {TW{1'b0}};
    end else if (timer_q != STUCK_MAX) begin
      timer_d = timer_q + TIMER_ONE;
    end else begin
      timer_d = timer_q;
    end
    stuck_set_s = (timer_q == STUCK_MAX);
  end

  // Sticky flag update: a set condition beats a simultaneous clear.
  always_comb begin
    if (ovr_set_s) begin
      overrun_d = 1'b1;
    end else if (i_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
    if (stuck_set_s) begin
      stuck_d = 1'b1;
    end else if (i_clr) begin
      stuck_d = 1'b0;
    end else begin
      stuck_d = stuck_q;
    end
  end

  // Stuck timer and sticky flag registers.
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      timer_q   <= {TW{1'b0}};
      overrun_q <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      overrun_q <= overrun_d;
      stuck_q   <= stuck_d;
    end
  end

  assign o_int_req     = req_q;
  assign o_int_overrun = overrun_q;
  assign o_int_stuck   = stuck_q;

`ifdef ACL_INT_EVT_COUNTER_EN
  localparam logic [C_CNT_BITS-1:0] CNT_MAX = {C_CNT_BITS{1'b1}};
  localparam logic [C_CNT_BITS-1:0] CNT_ONE = {{(C_CNT_BITS-1){1'b0}}, 1'b1};

  logic [C_CNT_BITS-1:0] cnt_q, cnt_d;

  // Saturating increment helper.
  function automatic logic [C_CNT_BITS-1:0] sat_inc(input logic [C_CNT_BITS-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  // Event counter next value; a clear together with a rise leaves one event.
  always_comb begin
    if (i_clr) begin
      if (rise_q) begin
        cnt_d = CNT_ONE;
      end else begin
        cnt_d = {C_CNT_BITS{1'b0}};
      end
    end else if (rise_q) begin
      cnt_d = sat_inc(cnt_q);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Event counter register.
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      cnt_q <= {C_CNT_BITS{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_evt_count = cnt_q;
`else
  // Event counter not built in this configuration.
`endif

endmodule
